nibble_serializer: RTL and testbench

- Upstream sequencer for the 4:1 bit multiplexer stage. Accepts a 4-bit word over a valid/ready handshake and holds it.
- Steps the 2-bit mux address (a1 = LSB, a2 = MSB) through all four lanes, emitting one selected bit per accepted output beat.
- Turns the mux into a parallel-to-serial converter with back-pressure. Includes its own internal lane select so the serial output can be checked standalone against an external mux driven by sel_a1/sel_a2.

---
 rtl/nibble_serializer_pkg.sv | 23 ++
 rtl/nibble_serializer_mux_addr_counter.sv | 32 +++
 rtl/nibble_serializer.sv | 113 +++++++++++
 tb/tb_nibble_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serializer_pkg.sv
// Shared types and constants for the nibble serializer.
// Holds FSM state encoding, lane geometry and lane-order helpers.
package nibble_serializer_pkg;

    localparam int LANES  = 4;
    localparam int ADDR_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // First lane emitted for a given bit order.
    function automatic logic [ADDR_W-1:0] lane_first(input bit msb_first);
        return msb_first ? ADDR_W'(LANES - 1) : '0;
    endfunction

    // Final lane emitted for a given bit order.
    function automatic logic [ADDR_W-1:0] lane_last(input bit msb_first);
        return msb_first ? '0 : ADDR_W'(LANES - 1);
    endfunction

endpackage

// File: rtl/nibble_serializer_mux_addr_counter.sv
// Mux address counter: steps the lane address up or down, reloads
// to the first lane, flags the last lane.
// Ports: clk, reset_n (sync, active-low), load, en -> count, last.
module mux_addr_counter
    import nibble_serializer_pkg::*;
#(
    parameter int              AW    = 2,
    parameter bit              DOWN  = 1'b0,
    parameter logic [AW-1:0]   FIRST = '0,
    parameter logic [AW-1:0]   LAST  = '1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          en,
    output logic [AW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= FIRST;
        end else if (load) begin
            count <= FIRST;
        end else if (en) begin
            count <= DOWN ? count - AW'(1) : count + AW'(1);
        end
    end

    assign last = (count == LAST);

endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial sequencer for a 4:1 bit mux with valid/ready.
// Ports: clk, reset_n, in_valid/in_ready/in_data, sel_a1/sel_a2,
//        out_valid/out_ready/out_bit/out_last, busy.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ADDR_W    = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_data,
    output logic             sel_a1,
    output logic             sel_a2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam logic [ADDR_W-1:0] LANE_FIRST = lane_first(MSB_FIRST);
    localparam logic [ADDR_W-1:0] LANE_LAST  = lane_last(MSB_FIRST);

    state_t            state;
    state_t            state_nx;
    logic [LANES-1:0]  hold;
    logic [ADDR_W-1:0] addr;
    logic              at_last;
    logic              accept;
    logic              beat;
    logic              cnt_load;
    logic              cnt_en;

    // Address returns to the first lane after every word, so the
    // idle sel value is always the next word's first lane.
    mux_addr_counter #(
        .AW    (ADDR_W),
        .DOWN  (MSB_FIRST),
        .FIRST (LANE_FIRST),
        .LAST  (LANE_LAST)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .en      (cnt_en),
        .count   (addr),
        .last    (at_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = reset_n;
                accept   = in_valid && in_ready;
                cnt_load = accept;
                if (accept) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_bit   = hold[addr];
                out_last  = at_last;
                beat      = out_ready;
                // Ready opens only on the completing last beat so a
                // new word can follow with no bubble.
                in_ready  = reset_n && at_last && out_ready;
                accept    = in_valid && in_ready;
                cnt_load  = beat && at_last;
                cnt_en    = beat && !at_last;
                if (beat && at_last && !accept) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (accept) begin
            hold <= in_data;
        end
    end

    assign sel_a1 = addr[0];
    assign sel_a2 = addr[1];

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer in both bit orders.
// Checks reset, beats, stalls, back-to-back words and mid-word reset.
module tb_nibble_serializer;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       l_in_valid, l_in_ready, l_out_ready;
    logic [3:0] l_in_data;
    logic       l_a1, l_a2, l_out_valid, l_out_bit, l_out_last, l_busy;

    logic       m_in_valid, m_in_ready, m_out_ready;
    logic [3:0] m_in_data;
    logic       m_a1, m_a2, m_out_valid, m_out_bit, m_out_last, m_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .in_data   (l_in_data),
        .sel_a1    (l_a1),
        .sel_a2    (l_a2),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .out_bit   (l_out_bit),
        .out_last  (l_out_last),
        .busy      (l_busy)
    );

    nibble_serializer #(.MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .in_data   (m_in_data),
        .sel_a1    (m_a1),
        .sel_a2    (m_a2),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_bit   (m_out_bit),
        .out_last  (m_out_last),
        .busy      (m_busy)
    );

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic l_beat(input string tag, input logic b,
                          input logic [1:0] s, input logic last);
        chk({tag, " valid"}, {3'b0, l_out_valid}, 4'd1);
        chk({tag, " bit"},   {3'b0, l_out_bit},   {3'b0, b});
        chk({tag, " sel"},   {2'b0, l_a2, l_a1},  {2'b0, s});
        chk({tag, " last"},  {3'b0, l_out_last},  {3'b0, last});
        step();
    endtask

    task automatic l_idle(input string tag);
        chk({tag, " idle valid"}, {3'b0, l_out_valid}, 4'd0);
        chk({tag, " idle busy"},  {3'b0, l_busy},      4'd0);
        chk({tag, " idle sel"},   {2'b0, l_a2, l_a1},  4'd0);
        chk({tag, " idle rdy"},   {3'b0, l_in_ready},  4'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        l_in_valid  = 1'b0;
        l_in_data   = 4'h0;
        l_out_ready = 1'b1;
        m_in_valid  = 1'b0;
        m_in_data   = 4'h0;
        m_out_ready = 1'b1;

        step();
        chk("rst valid", {3'b0, l_out_valid}, 4'd0);
        chk("rst ready", {3'b0, l_in_ready},  4'd0);
        chk("rst sel",   {2'b0, l_a2, l_a1},  4'd0);
        chk("rst msb sel", {2'b0, m_a2, m_a1}, 4'b0011);
        step();
        chk("rst2 ready", {3'b0, l_in_ready}, 4'd0);
        reset_n = 1'b1;
        step();
        chk("rel ready", {3'b0, l_in_ready}, 4'd1);
        chk("rel busy",  {3'b0, l_busy},     4'd0);

        // single word 1010
        l_in_valid = 1'b1;
        l_in_data  = 4'b1010;
        step();
        l_in_valid = 1'b0;
        l_in_data  = 4'bxxxx;
        chk("w1 busy", {3'b0, l_busy}, 4'd1);
        chk("w1 rdy",  {3'b0, l_in_ready}, 4'd0);
        l_beat("w1 b0", 1'b0, 2'd0, 1'b0);
        l_beat("w1 b1", 1'b1, 2'd1, 1'b0);
        l_beat("w1 b2", 1'b0, 2'd2, 1'b0);
        l_beat("w1 b3", 1'b1, 2'd3, 1'b1);
        l_idle("w1");
        step();

        // back-pressure 0110
        l_in_valid = 1'b1;
        l_in_data  = 4'b0110;
        step();
        l_in_valid = 1'b0;
        l_beat("bp b0", 1'b0, 2'd0, 1'b0);
        l_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            l_beat("bp stall", 1'b1, 2'd1, 1'b0);
            chk("bp stall rdy", {3'b0, l_in_ready}, 4'd0);
        end
        l_out_ready = 1'b1;
        l_beat("bp b1", 1'b1, 2'd1, 1'b0);
        l_beat("bp b2", 1'b1, 2'd2, 1'b0);
        l_beat("bp b3", 1'b0, 2'd3, 1'b1);
        l_idle("bp");

        // back-to-back 1111 then 0001
        l_in_valid = 1'b1;
        l_in_data  = 4'b1111;
        step();
        l_in_data  = 4'b0001;
        l_beat("bb a0", 1'b1, 2'd0, 1'b0);
        l_beat("bb a1", 1'b1, 2'd1, 1'b0);
        chk("bb mid rdy", {3'b0, l_in_ready}, 4'd0);
        l_beat("bb a2", 1'b1, 2'd2, 1'b0);
        chk("bb last rdy", {3'b0, l_in_ready}, 4'd1);
        l_beat("bb a3", 1'b1, 2'd3, 1'b1);
        l_in_valid = 1'b0;
        chk("bb no bubble", {3'b0, l_busy}, 4'd1);
        l_beat("bb b0", 1'b1, 2'd0, 1'b0);
        l_beat("bb b1", 1'b0, 2'd1, 1'b0);
        l_beat("bb b2", 1'b0, 2'd2, 1'b0);
        l_beat("bb b3", 1'b0, 2'd3, 1'b1);
        l_idle("bb");

        // MSB-first 1000
        chk("m rdy", {3'b0, m_in_ready}, 4'd1);
        m_in_valid = 1'b1;
        m_in_data  = 4'b1000;
        step();
        m_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            logic [3:0] d;
            s = 2'(3 - i);
            d = 4'b1000;
            chk("m valid", {3'b0, m_out_valid}, 4'd1);
            chk("m sel",   {2'b0, m_a2, m_a1},  {2'b0, s});
            chk("m bit",   {3'b0, m_out_bit},   {3'b0, d[s]});
            chk("m last",  {3'b0, m_out_last},  {3'b0, s == 2'd0});
            step();
        end
        chk("m idle valid", {3'b0, m_out_valid}, 4'd0);
        chk("m idle sel",   {2'b0, m_a2, m_a1},  4'b0011);

        // reset mid-word 1100
        l_in_valid = 1'b1;
        l_in_data  = 4'b1100;
        step();
        l_in_valid = 1'b0;
        l_beat("mr b0", 1'b0, 2'd0, 1'b0);
        l_beat("mr b1", 1'b0, 2'd1, 1'b0);
        chk("mr b2 bit", {3'b0, l_out_bit}, 4'd1);
        reset_n = 1'b0;
        #1;
        chk("mr rst rdy", {3'b0, l_in_ready}, 4'd0);
        step();
        chk("mr valid", {3'b0, l_out_valid}, 4'd0);
        chk("mr busy",  {3'b0, l_busy},      4'd0);
        chk("mr sel",   {2'b0, l_a2, l_a1},  4'd0);
        reset_n    = 1'b1;
        l_in_valid = 1'b1;
        l_in_data  = 4'b0011;
        step();
        l_in_valid = 1'b0;
        l_beat("mr w0", 1'b1, 2'd0, 1'b0);
        l_beat("mr w1", 1'b1, 2'd1, 1'b0);
        l_beat("mr w2", 1'b0, 2'd2, 1'b0);
        l_beat("mr w3", 1'b0, 2'd3, 1'b1);
        l_idle("mr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
